// File: rtl/ascii_rx_parser.sv
// ascii_rx_parser
//   Pops ASCII bytes from a first-word-fall-through UART RX FIFO and parses
//   time-set frames of the form "HH:MM:SS" terminated by CR or LF. Every
//   character is validated and each field is range-checked. A fully valid
//   frame updates the six BCD outputs and raises a one-cycle oSet strobe.
//   A malformed frame, or one that stalls longer than P_TIMEOUT cycles
//   between bytes, raises a one-cycle oErr strobe. The parser then resyncs
//   to the start of the next frame.
//
// Handshake: oPop is high whenever the FIFO is non-empty (and not in reset).
//   A byte is consumed on every rising edge where oPop=1. iRx_Data is looked
//   at only in those cycles.
//
// Ports
//   iClk, iRst            clock (rising edge), async active-high reset
//   iEmpty, iRx_Data      FIFO empty flag and head byte
//   oPop                  head byte consumed this cycle
//   oHour_10 .. oSec_1    held BCD time digits
//   oSet                  one-cycle strobe: new valid time on BCD outputs
//   oErr                  one-cycle strobe: frame rejected or timed out
//   oState                current parser state (debug observation)
module ascii_rx_parser #(
    parameter int P_TIMEOUT = 100_000_000,
    parameter int P_CNT_W   = 27
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEmpty,
    input  logic [7:0] iRx_Data,
    output logic       oPop,
    output logic [3:0] oHour_10,
    output logic [3:0] oHour_1,
    output logic [3:0] oMin_10,
    output logic [3:0] oMin_1,
    output logic [3:0] oSec_10,
    output logic [3:0] oSec_1,
    output logic       oSet,
    output logic       oErr,
    output logic [3:0] oState
);

    typedef enum logic [3:0] {
        S_H10 = 4'd0,
        S_H1  = 4'd1,
        S_C1  = 4'd2,
        S_M10 = 4'd3,
        S_M1  = 4'd4,
        S_C2  = 4'd5,
        S_S10 = 4'd6,
        S_S1  = 4'd7,
        S_END = 4'd8
    } state_t;

    localparam logic [P_CNT_W-1:0] LP_CNT_MAX = P_CNT_W'(P_TIMEOUT - 1);

    state_t             state;
    state_t             stateNext;
    logic [P_CNT_W-1:0] cnt;
    logic [3:0]         shH10, shH1, shM10, shM1, shS10, shS1;

    logic       isDigit;
    logic       isColon;
    logic       isEol;
    logic [3:0] digit;
    logic       accept;
    logic       reject;
    logic       done;
    logic       timeoutHit;

    assign oPop   = !iEmpty && !iRst;
    assign oState = state;

    // For ASCII '0'-'9' (0x30-0x39) the low nibble equals iRx_Data - 8'h30.
    assign digit   = iRx_Data[3:0];
    assign isDigit = (iRx_Data >= 8'h30) && (iRx_Data <= 8'h39);
    assign isColon = (iRx_Data == 8'h3A);
    assign isEol   = (iRx_Data == 8'h0D) || (iRx_Data == 8'h0A);

    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        reject     = 1'b0;
        done       = 1'b0;
        timeoutHit = 1'b0;

        if (oPop) begin
            case (state)
                S_H10: begin
                    if (isDigit && digit <= 4'd2) begin
                        accept    = 1'b1;
                        stateNext = S_H1;
                    end else if (!isEol) begin
                        // Stray CR/LF between frames is dropped silently.
                        reject = 1'b1;
                    end
                end
                S_H1: begin
                    if (isDigit && (shH10 != 4'd2 || digit <= 4'd3)) begin
                        accept    = 1'b1;
                        stateNext = S_C1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                S_C1: begin
                    if (isColon) stateNext = S_M10;
                    else         reject    = 1'b1;
                end
                S_M10: begin
                    if (isDigit && digit <= 4'd5) begin
                        accept    = 1'b1;
                        stateNext = S_M1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                S_M1: begin
                    if (isDigit) begin
                        accept    = 1'b1;
                        stateNext = S_C2;
                    end else begin
                        reject = 1'b1;
                    end
                end
                S_C2: begin
                    if (isColon) stateNext = S_S10;
                    else         reject    = 1'b1;
                end
                S_S10: begin
                    if (isDigit && digit <= 4'd5) begin
                        accept    = 1'b1;
                        stateNext = S_S1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                S_S1: begin
                    if (isDigit) begin
                        accept    = 1'b1;
                        stateNext = S_END;
                    end else begin
                        reject = 1'b1;
                    end
                end
                S_END: begin
                    if (isEol) begin
                        done      = 1'b1;
                        stateNext = S_H10;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: reject = 1'b1;
            endcase
            if (reject) stateNext = S_H10;
        end else if (state != S_H10 && cnt == LP_CNT_MAX) begin
            // A pop in the same cycle keeps the frame alive, hence the else.
            timeoutHit = 1'b1;
            stateNext  = S_H10;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= S_H10;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt <= '0;
        end else if (oPop || state == S_H10 || timeoutHit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            shH10 <= 4'd0;
            shH1  <= 4'd0;
            shM10 <= 4'd0;
            shM1  <= 4'd0;
            shS10 <= 4'd0;
            shS1  <= 4'd0;
        end else if (reject || timeoutHit) begin
            shH10 <= 4'd0;
            shH1  <= 4'd0;
            shM10 <= 4'd0;
            shM1  <= 4'd0;
            shS10 <= 4'd0;
            shS1  <= 4'd0;
        end else if (accept) begin
            case (state)
                S_H10:   shH10 <= digit;
                S_H1:    shH1  <= digit;
                S_M10:   shM10 <= digit;
                S_M1:    shM1  <= digit;
                S_S10:   shS10 <= digit;
                S_S1:    shS1  <= digit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oHour_10 <= 4'd0;
            oHour_1  <= 4'd0;
            oMin_10  <= 4'd0;
            oMin_1   <= 4'd0;
            oSec_10  <= 4'd0;
            oSec_1   <= 4'd0;
            oSet     <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            oSet <= done;
            oErr <= reject || timeoutHit;
            if (done) begin
                oHour_10 <= shH10;
                oHour_1  <= shH1;
                oMin_10  <= shM10;
                oMin_1   <= shM1;
                oSec_10  <= shS10;
                oSec_1   <= shS1;
            end
        end
    end

endmodule

// File: tb/tb_ascii_rx_parser.sv
// tb_ascii_rx_parser
//   Bench for ascii_rx_parser with a short timeout (16 cycles).
//   A frame table lists each input string with the strobe events it must
//   produce, in order. These are 'S' for oSet and 'E' for oErr. The table
//   also gives the BCD value that must be held afterwards. Expected events
//   go onto a queue when a frame is driven. A monitor pops and compares them
//   whenever the DUT strobes.
module tb_ascii_rx_parser;

    localparam int TO = 16;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iEmpty;
    logic [7:0] iRx_Data;
    logic       oPop;
    logic [3:0] oHour_10, oHour_1, oMin_10, oMin_1, oSec_10, oSec_1;
    logic       oSet, oErr;
    logic [3:0] oState;

    ascii_rx_parser #(.P_TIMEOUT(TO), .P_CNT_W(5)) dut (
        .iClk(iClk), .iRst(iRst), .iEmpty(iEmpty), .iRx_Data(iRx_Data),
        .oPop(oPop),
        .oHour_10(oHour_10), .oHour_1(oHour_1), .oMin_10(oMin_10),
        .oMin_1(oMin_1), .oSec_10(oSec_10), .oSec_1(oSec_1),
        .oSet(oSet), .oErr(oErr), .oState(oState)
    );

    // ---------------- clock ----------------
    always #5 iClk = ~iClk;

    wire [23:0] bcd = {oHour_10, oHour_1, oMin_10, oMin_1, oSec_10, oSec_1};

    int tests_run = 0;
    int tests_failed = 0;
    int pop_bad = 0;
    int pop_cnt = 0;
    logic [23:0] cur_bcd = 24'h0;

    // Expected strobe events: {set, err, bcd}
    logic [25:0] exp_q[$];

    typedef struct {
        string       txt;
        int          max_gap;
        string       ev;
        logic [23:0] after;
    } frame_vec_t;

    frame_vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oPop !== !iEmpty) pop_bad++;
            if (oPop) pop_cnt++;
            if (oSet || oErr) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_event: got set=%0b err=%0b bcd=%06h expected none",
                             oSet, oErr, bcd);
                end else begin
                    check("event", {6'd0, oSet, oErr, bcd}, {6'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        iRx_Data = b;
        iEmpty   = 1'b0;
        @(posedge iClk);
        #1;
        iEmpty   = 1'b1;
        iRx_Data = 8'($urandom_range(255, 0));
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                @(posedge iClk);
                #1;
            end
            send_byte(s[i]);
        end
    endtask

    task automatic run_frame(input string s, input int max_gap, input string ev,
                             input logic [23:0] after);
        for (int i = 0; i < ev.len(); i++) begin
            if (ev[i] == 8'h53) exp_q.push_back({2'b10, after});
            else                exp_q.push_back({2'b01, cur_bcd});
        end
        cur_bcd = after;
        send_str(s, max_gap);
        repeat (4) begin
            @(posedge iClk);
            #1;
        end
        check({"drained ", s}, exp_q.size(), 0);
        check({"held ", s}, bcd, after);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        int got;

        vecs[0]  = '{"12:34:56\015",       0, "S",      24'h123456};
        vecs[1]  = '{"24:00:00\015",       0, "EEE",    24'h123456};
        vecs[2]  = '{"23:59:59\n",         0, "S",      24'h235959};
        vecs[3]  = '{"12-34:56\015",       0, "EEEEEE", 24'h235959};
        vecs[4]  = '{"07:08:09\015",       0, "S",      24'h070809};
        vecs[5]  = '{"19:60:00\015",       0, "EEE",    24'h070809};
        vecs[6]  = '{"23:45:67\015",       0, "EE",     24'h070809};
        vecs[7]  = '{"29:00:00\015",       0, "EEE",    24'h070809};
        vecs[8]  = '{"20:00:00\n",         0, "S",      24'h200000};
        vecs[9]  = '{"09:59:59\015\n",     0, "S",      24'h095959};
        vecs[10] = '{"12:34:56:",          0, "E",      24'h095959};
        vecs[11] = '{"\015\n05:06:07\015", 8, "S",      24'h050607};
        vecs[12] = '{"23:59:59\015",       3, "S",      24'h235959};

        // Reset state, with a byte offered to confirm oPop stays low.
        iRst     = 1'b1;
        iEmpty   = 1'b0;
        iRx_Data = 8'h31;
        #12;
        check("rst_bcd",   bcd,    24'h0);
        check("rst_pop",   oPop,   1'b0);
        check("rst_state", oState, 4'd0);
        check("rst_set",   oSet,   1'b0);
        check("rst_err",   oErr,   1'b0);
        iEmpty = 1'b1;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        repeat (2) begin
            @(posedge iClk);
            #1;
        end

        // Back-to-back frame: pop count and oSet latency.
        exp_q.push_back({2'b10, 24'h123456});
        cur_bcd = 24'h123456;
        p0 = pop_cnt;
        send_str("12:34:56", 0);
        send_byte(8'h0D);
        check("lat_set_high", oSet, 1'b1);
        check("lat_err_low",  oErr, 1'b0);
        check("lat_bcd",      bcd,  24'h123456);
        @(posedge iClk);
        #1;
        check("lat_set_pulse", oSet, 1'b0);
        check("pop_count",     pop_cnt - p0, 9);

        // Table-driven frames.
        for (int v = 0; v < 13; v++) begin
            run_frame(vecs[v].txt, vecs[v].max_gap, vecs[v].ev, vecs[v].after);
        end

        // Asynchronous reset mid-frame.
        send_str("12:", 0);
        #2;
        iRst = 1'b1;
        #1;
        check("mid_rst_bcd",   bcd,    24'h0);
        check("mid_rst_state", oState, 4'd0);
        iEmpty = 1'b0;
        #1;
        check("mid_rst_pop", oPop, 1'b0);
        iEmpty = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        cur_bcd = 24'h0;
        run_frame("01:02:03\015", 0, "S", 24'h010203);

        // Inter-byte timeout: oErr 16 edges after the last pop edge.
        exp_q.push_back({2'b01, cur_bcd});
        send_str("12:3", 0);
        got = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge iClk);
            #1;
            if (oErr) begin
                got = n;
                break;
            end
        end
        check("timeout_latency", got, TO);
        check("timeout_state",   oState, 4'd0);
        run_frame("00:00:00\015", 0, "S", 24'h000000);

        repeat (5) @(posedge iClk);
        #1;
        check("pop_follows_empty", pop_bad, 0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
